lcd_page_scheduler: RTL and testbench

- Decides which 2-line page the character-LCD driver shows and when it must repaint.
- Rotates normal pages (ODO, FUEL, TRIP) on a timer or button press.
- Preempts rotation with prioritised alarm pages (side brake, low fuel, overspeed, door).
- Hands each page decision to the LCD driver over a req/ack handshake; sits between the vehicle-status logic and the LCD driver.

---
 rtl/lcd_page_scheduler.sv | 135 +++++++++++++
 tb/tb_lcd_page_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_page_scheduler.sv
// Chooses the page the character LCD shows (rotating normal pages or prioritised
// alarm pages) and hands each repaint to the LCD driver over a req/ack handshake.
module lcd_page_scheduler #(
  parameter int TICK_DIV    = 50_000,
  parameter int NUM_PAGES   = 3,
  parameter int ROTATE_MS   = 3000,
  parameter int MIN_HOLD_MS = 1000,
  parameter int REFRESH_MS  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] alarm_req,
  input  logic       page_next,
  input  logic       upd_ack,
  output logic       upd_req,
  output logic [2:0] page_sel,
  output logic       alarm_active
);

  localparam int            TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [15:0]   ROTATE_LIM   = 16'(ROTATE_MS);
  localparam logic [15:0]   MIN_HOLD_LIM = 16'(MIN_HOLD_MS);
  localparam logic [15:0]   REFRESH_LIM  = 16'(REFRESH_MS);
  localparam logic [1:0]    LAST_PAGE    = 2'(NUM_PAGES - 1);

  typedef enum logic {NORMAL, ALARM} state_t;

  state_t        state, state_n;
  logic [1:0]    norm_idx, norm_idx_n;
  logic [1:0]    alarm_idx, alarm_idx_n;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   hold_ms;
  logic [15:0]   refresh_ms;
  logic          pending;
  logic          target_chg;
  logic          refresh_hit;
  logic [2:0]    target;
  logic [1:0]    top_alarm;
  logic          any_alarm;

  assign tick        = (tick_cnt == TICK_LAST);
  assign refresh_hit = (refresh_ms >= REFRESH_LIM);
  assign any_alarm   = |alarm_req;
  assign target      = (state == ALARM) ? {1'b1, alarm_idx} : {1'b0, norm_idx};

  // Lowest set bit wins: bit 0 (side brake) is the most urgent alarm.
  always_comb begin
    top_alarm = 2'd0;
    if (alarm_req[0])      top_alarm = 2'd0;
    else if (alarm_req[1]) top_alarm = 2'd1;
    else if (alarm_req[2]) top_alarm = 2'd2;
    else if (alarm_req[3]) top_alarm = 2'd3;
  end

  always_comb begin
    state_n     = state;
    norm_idx_n  = norm_idx;
    alarm_idx_n = alarm_idx;
    target_chg  = 1'b0;
    case (state)
      NORMAL: begin
        if (any_alarm) begin
          state_n     = ALARM;
          alarm_idx_n = top_alarm;
          target_chg  = 1'b1;
        end else if (page_next || hold_ms >= ROTATE_LIM) begin
          norm_idx_n = (norm_idx == LAST_PAGE) ? 2'd0 : norm_idx + 2'd1;
          target_chg = 1'b1;
        end
      end
      ALARM: begin
        // Higher priority preempts at once; otherwise the page is held for the
        // minimum time and until its own request clears. The stored normal
        // index is resumed unchanged.
        if (any_alarm && top_alarm < alarm_idx) begin
          alarm_idx_n = top_alarm;
          target_chg  = 1'b1;
        end else if (hold_ms >= MIN_HOLD_LIM && !alarm_req[alarm_idx]) begin
          if (any_alarm) alarm_idx_n = top_alarm;
          else           state_n     = NORMAL;
          target_chg = 1'b1;
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= NORMAL;
      norm_idx     <= 2'd0;
      alarm_idx    <= 2'd0;
      alarm_active <= 1'b0;
      tick_cnt     <= '0;
      hold_ms      <= 16'd0;
      refresh_ms   <= 16'd0;
    end else begin
      state        <= state_n;
      norm_idx     <= norm_idx_n;
      alarm_idx    <= alarm_idx_n;
      alarm_active <= (state_n == ALARM);
      tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
      if (target_chg) begin
        hold_ms    <= 16'd0;
        refresh_ms <= 16'd0;
      end else begin
        if (tick && hold_ms != 16'hFFFF) hold_ms <= hold_ms + 16'd1;
        if (refresh_hit)  refresh_ms <= 16'd0;
        else if (tick)    refresh_ms <= refresh_ms + 16'd1;
      end
    end
  end

  // Handshake: upd_req rises when work is pending, page_sel is captured at that
  // moment and frozen until upd_ack; at least one low cycle between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_req  <= 1'b0;
      page_sel <= 3'd0;
      pending  <= 1'b1;
    end else begin
      if (target_chg || refresh_hit) pending <= 1'b1;
      else if (!upd_req)             pending <= 1'b0;
      if (upd_req) begin
        if (upd_ack) upd_req <= 1'b0;
      end else if (pending) begin
        upd_req  <= 1'b1;
        page_sel <= target;
      end
    end
  end

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Directed bench for lcd_page_scheduler with small timing parameters
// (10 clk per ms, 30 ms rotation, 10 ms alarm hold).
module tb_lcd_page_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alarm_req;
  logic       page_next;
  logic       upd_ack;
  logic       upd_req;
  logic [2:0] page_sel;
  logic       alarm_active;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int w, t0, last, hi_cnt;
  int exp_pages [4] = '{1, 2, 0, 1};

  lcd_page_scheduler #(
    .TICK_DIV(10), .NUM_PAGES(3), .ROTATE_MS(30), .MIN_HOLD_MS(10), .REFRESH_MS(1000)
  ) dut (
    .clk(clk), .rst(rst), .alarm_req(alarm_req), .page_next(page_next),
    .upd_ack(upd_ack), .upd_req(upd_req), .page_sel(page_sel), .alarm_active(alarm_active)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // driver tasks
  task automatic wait_req(input string tag, input int max, output int waited);
    waited = 0;
    @(negedge clk);
    while (upd_req !== 1'b1 && waited < max) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_req"}, upd_req, 1);
  endtask

  task automatic serve(input string tag, input int exp_page, input logic exp_alarm);
    check({tag, "_page"}, page_sel, exp_page);
    check({tag, "_alarm"}, alarm_active, exp_alarm);
    repeat (3) @(negedge clk);
    upd_ack = 1'b1;
    @(negedge clk);
    upd_ack = 1'b0;
    check({tag, "_drop"}, upd_req, 0);
  endtask

  task automatic pulse_next();
    page_next = 1'b1;
    @(negedge clk);
    page_next = 1'b0;
  endtask

  initial begin
    rst = 1'b0; alarm_req = 4'd0; page_next = 1'b0; upd_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", upd_req, 0);
    check("rst_page", page_sel, 0);
    check("rst_alarm", alarm_active, 0);

    // first request on the first edge after release
    rst = 1'b1;
    @(negedge clk);
    check("first_req", upd_req, 1);
    last = cyc;
    serve("first", 0, 1'b0);

    // timed rotation 1, 2, 0, 1 about 300 cycles apart
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("rot%0d", i), 320, w);
      check_range($sformatf("rot%0d_gap", i), cyc - last, 294, 306);
      last = cyc;
      serve($sformatf("rot%0d", i), exp_pages[i], 1'b0);
    end

    // button at page 1 advances to 2 and restarts the rotation timer
    repeat (100) @(negedge clk);
    pulse_next();
    wait_req("btn", 5, w);
    check_range("btn_lat", w, 0, 1);
    last = cyc;
    serve("btn", 2, 1'b0);
    wait_req("btn_rot", 320, w);
    check_range("btn_rot_gap", cyc - last, 288, 300);
    serve("btn_rot", 0, 1'b0);

    // overspeed alarm over page 1, held for the minimum time after it drops
    pulse_next();
    wait_req("to_p1", 5, w);
    serve("to_p1", 1, 1'b0);
    alarm_req = 4'b0100;
    t0 = cyc;
    wait_req("al6", 5, w);
    check_range("al6_lat", w, 0, 1);
    serve("al6", 6, 1'b1);
    repeat (16) @(negedge clk);
    alarm_req = 4'b0000;
    repeat (56) @(negedge clk);
    check("al6_hold_req", upd_req, 0);
    check("al6_hold_page", page_sel, 6);
    wait_req("al6_exit", 60, w);
    check_range("al6_exit_gap", cyc - t0, 92, 102);
    serve("al6_exit", 1, 1'b0);

    // side brake preempts overspeed; door takes over when both clear
    alarm_req = 4'b0100;
    wait_req("al6b", 5, w);
    serve("al6b", 6, 1'b1);
    alarm_req = 4'b0101;
    t0 = cyc;
    wait_req("al4", 5, w);
    check_range("al4_lat", w, 0, 1);
    serve("al4", 4, 1'b1);
    repeat (134) @(negedge clk);
    check("al4_stay_req", upd_req, 0);
    check("al4_stay_page", page_sel, 4);
    repeat (10) @(negedge clk);
    alarm_req = 4'b1000;
    wait_req("al7", 5, w);
    check_range("al7_lat", w, 0, 1);
    serve("al7", 7, 1'b1);
    alarm_req = 4'b0000;
    last = cyc;
    wait_req("al7_exit", 120, w);
    check_range("al7_exit_gap", cyc - last, 88, 102);
    serve("al7_exit", 1, 1'b0);

    // withheld ack: page_sel frozen, changes collapse into one later request
    pulse_next();
    wait_req("hold", 5, w);
    check("hold_page0", page_sel, 2);
    repeat (100) @(negedge clk);
    check("hold_req_a", upd_req, 1);
    check("hold_page_a", page_sel, 2);
    repeat (150) @(negedge clk);
    pulse_next();
    check("hold_page_b", page_sel, 2);
    repeat (49) @(negedge clk);
    pulse_next();
    repeat (199) @(negedge clk);
    check("hold_req_c", upd_req, 1);
    check("hold_page_c", page_sel, 2);
    upd_ack = 1'b1;
    @(negedge clk);
    upd_ack = 1'b0;
    check("hold_gap_low", upd_req, 0);
    @(negedge clk);
    check("hold_reissue", upd_req, 1);
    serve("hold_final", 1, 1'b0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      upd_ack = (i == 6);
      @(negedge clk);
      if (upd_req) hi_cnt++;
    end
    upd_ack = 1'b0;
    check("single_req", hi_cnt, 0);

    // asynchronous reset in the middle of an alarm request
    alarm_req = 4'b0010;
    wait_req("al5", 5, w);
    check("al5_page", page_sel, 5);
    check("al5_alarm", alarm_active, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_req", upd_req, 0);
    check("arst_page", page_sel, 0);
    check("arst_alarm", alarm_active, 0);
    alarm_req = 4'b0000;
    repeat (2) @(negedge clk);
    check("arst_hold_req", upd_req, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_req", upd_req, 1);
    check("rel_page", page_sel, 0);
    check("rel_alarm", alarm_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
